// File: rtl/ad5318_pkg.sv
// Shared types and constants for the AD5318 update scheduler.
package ad5318_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned DATA_W = 10;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StArb,
        StSend,
        StWaitLo,
        StWaitHi,
        StLdac
    } state_e;

    function automatic logic [15:0] data_word(input logic [DATA_W-1:0] value);
        return {{(16 - DATA_W){1'b0}}, value};
    endfunction

endpackage

// File: rtl/ad5318_update_scheduler_if.sv
// Stream link from the scheduler to the AD5318 serial driver.
interface ad5318_update_scheduler_if;

    logic [15:0] m_tdata;
    logic [2:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tready;

    modport master (output m_tdata, output m_tuser, output m_tvalid, input m_tready);
    modport slave  (input m_tdata, input m_tuser, input m_tvalid, output m_tready);

endinterface

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin pick: first set bit after rr_i, wrapping.
module rr_arbiter8 (
    input  logic [7:0] pending_i,
    input  logic [2:0] rr_i,
    output logic [2:0] grant_o,
    output logic       valid_o
);

    logic [2:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        // Scan from farthest to nearest so the nearest hit is written last.
        for (int i = 8; i >= 1; i--) begin
            idx = rr_i + 3'(i);
            if (pending_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ad5318_update_scheduler.sv
// Round-robin setpoint scheduler for a shared AD5318 driver with batched LDAC.
// Optional periodic refresh of all channels under `AUTO_REFRESH_EN.
module ad5318_update_scheduler
    import ad5318_pkg::*;
#(
    parameter logic [15:0] CFG_WORD       = 16'h8000,
    parameter int unsigned LDAC_PULSE     = 4,
    parameter logic [23:0] REFRESH_PERIOD = 24'd1_000_000
) (
    input  logic                       clkin,
    input  logic                       rstn,
    input  logic                       wr_en,
    input  logic [CH_W-1:0]            wr_ch,
    input  logic [DATA_W-1:0]          wr_data,
    ad5318_update_scheduler_if.master  m,
    output logic                       ldac_b,
    output logic [NUM_CH-1:0]          pending,
    output logic                       busy
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shadow_q [NUM_CH];
    logic [DATA_W-1:0]   shadow_d [NUM_CH];
    logic [NUM_CH-1:0]   pending_q, pending_d, pending_w, wr_mask;
    logic [CH_W-1:0]     rr_q, rr_d, gnt;
    logic                gnt_valid;
    logic [15:0]         tdata_q, tdata_d;
    logic [CH_W-1:0]     tuser_q, tuser_d;
    logic                tvalid_q, tvalid_d;
    logic                ldac_b_q, ldac_b_d;
    logic [3:0]          ldac_cnt_q, ldac_cnt_d;
    logic                sent_any_q, sent_any_d;
`ifdef AUTO_REFRESH_EN
    logic [23:0]         refresh_cnt_q, refresh_cnt_d;
    logic                init_done_q, init_done_d;
`else
    logic                unused_refresh;
    assign unused_refresh = ^REFRESH_PERIOD;
`endif

    rr_arbiter8 u_arb (
        .pending_i (pending_q),
        .rr_i      (rr_q),
        .grant_o   (gnt),
        .valid_o   (gnt_valid)
    );

    assign wr_mask   = wr_en ? (NUM_CH'(1) << wr_ch) : '0;
    // A write landing this cycle counts as pending for IDLE/WAIT_HI decisions.
    assign pending_w = pending_q | wr_mask;

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        rr_d       = rr_q;
        tdata_d    = tdata_q;
        tuser_d    = tuser_q;
        tvalid_d   = tvalid_q;
        ldac_b_d   = ldac_b_q;
        ldac_cnt_d = ldac_cnt_q;
        sent_any_d = sent_any_q;
`ifdef AUTO_REFRESH_EN
        refresh_cnt_d = refresh_cnt_q;
        init_done_d   = init_done_q;
`endif
        unique case (state_q)
            StInit: begin
                tdata_d  = CFG_WORD;
                tuser_d  = '0;
                tvalid_d = 1'b1;
                state_d  = StSend;
`ifdef AUTO_REFRESH_EN
                init_done_d = 1'b1;
`endif
            end
            StIdle: begin
                if (pending_w != '0) state_d = StArb;
            end
            StArb: begin
                if (gnt_valid) begin
                    pending_d[gnt] = 1'b0;
                    rr_d           = gnt;
                    tdata_d        = data_word(shadow_q[gnt]);
                    tuser_d        = gnt;
                    tvalid_d       = 1'b1;
                    sent_any_d     = 1'b1;
                    state_d        = StSend;
                end else begin
                    state_d = StIdle;
                end
            end
            StSend: begin
                if (m.m_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = StWaitLo;
                end
            end
            StWaitLo: begin
                if (!m.m_tready) state_d = StWaitHi;
            end
            StWaitHi: begin
                if (m.m_tready) begin
                    if (pending_w != '0) begin
                        state_d = StArb;
                    end else if (sent_any_q) begin
                        ldac_b_d   = 1'b0;
                        ldac_cnt_d = 4'(LDAC_PULSE - 1);
                        state_d    = StLdac;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StLdac: begin
                if (ldac_cnt_q == '0) begin
                    ldac_b_d   = 1'b1;
                    sent_any_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    ldac_cnt_d = ldac_cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Applied after the grant clear so a same-cycle write wins.
        if (wr_en) begin
            shadow_d[wr_ch]  = wr_data;
            pending_d[wr_ch] = 1'b1;
        end

`ifdef AUTO_REFRESH_EN
        if (!init_done_q) begin
            refresh_cnt_d = '0;
        end else if (refresh_cnt_q == REFRESH_PERIOD - 24'd1) begin
            refresh_cnt_d = '0;
            pending_d     = '1;
        end else begin
            refresh_cnt_d = refresh_cnt_q + 24'd1;
        end
`endif
    end

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state_q    <= StInit;
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
            pending_q  <= '0;
            rr_q       <= 3'd7;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tvalid_q   <= 1'b0;
            ldac_b_q   <= 1'b1;
            ldac_cnt_q <= '0;
            sent_any_q <= 1'b0;
`ifdef AUTO_REFRESH_EN
            refresh_cnt_q <= '0;
            init_done_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            tvalid_q   <= tvalid_d;
            ldac_b_q   <= ldac_b_d;
            ldac_cnt_q <= ldac_cnt_d;
            sent_any_q <= sent_any_d;
`ifdef AUTO_REFRESH_EN
            refresh_cnt_q <= refresh_cnt_d;
            init_done_q   <= init_done_d;
`endif
        end
    end

    assign m.m_tdata  = tdata_q;
    assign m.m_tuser  = tuser_q;
    assign m.m_tvalid = tvalid_q;
    assign ldac_b     = ldac_b_q;
    assign pending    = pending_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ad5318_update_scheduler.sv
// Directed bench: a driver model cycles tready after each word; words and LDAC pulses are logged.
module tb_ad5318_update_scheduler;

    logic       clkin = 1'b0;
    logic       rstn = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = '0;
    logic [9:0] wr_data = '0;
    logic       ldac_b;
    logic [7:0] pending;
    logic       busy;
    logic       tready = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    logic [18:0] words[$];
    int          lo_cnt = 0;
    int          ldac_pulses = 0;
    int          cur_w = 0;
    int          last_w = 0;
    logic        ldac_prev = 1'b1;

    ad5318_update_scheduler_if m_if ();
    assign m_if.m_tready = tready;

    ad5318_update_scheduler dut (
        .clkin   (clkin),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .m       (m_if),
        .ldac_b  (ldac_b),
        .pending (pending),
        .busy    (busy)
    );

    always #5 clkin = ~clkin;

    // Driver model and monitor, sampled on the falling edge.
    always @(negedge clkin) begin
        if (lo_cnt != 0) begin
            tready = (lo_cnt == 1);
            lo_cnt--;
        end else if (m_if.m_tvalid && tready) begin
            words.push_back({m_if.m_tuser, m_if.m_tdata});
            lo_cnt = 3;
        end
        if (ldac_prev && !ldac_b) begin
            ldac_pulses++;
            cur_w = 1;
        end else if (!ldac_b) begin
            cur_w++;
        end else if (!ldac_prev) begin
            last_w = cur_w;
        end
        ldac_prev = ldac_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [9:0] data);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = data;
        @(negedge clkin);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (2) @(negedge clkin);
        while (busy && n < 300) begin
            @(negedge clkin);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
        @(negedge clkin);
    endtask

    task automatic clear_log();
        words.delete();
        ldac_pulses = 0;
        last_w = 0;
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clkin);
        rstn  = 1'b0;
        wr_en = 1'b0;
        repeat (3) @(negedge clkin);
        if (chk) begin
            check("rst_tvalid", 32'(m_if.m_tvalid), 32'd0);
            check("rst_tdata", 32'(m_if.m_tdata), 32'd0);
            check("rst_tuser", 32'(m_if.m_tuser), 32'd0);
            check("rst_ldac_b", 32'(ldac_b), 32'd1);
            check("rst_pending", 32'(pending), 32'd0);
            check("rst_busy", 32'(busy), 32'd1);
        end
        clear_log();
        rstn = 1'b1;
        wait_idle("init");
    endtask

    initial begin
        // Reset and one-time control word
        do_reset(1'b1);
        check("cfg_count", 32'(words.size()), 32'd1);
        check("cfg_word", 32'(words[0]), {13'd0, 3'd0, 16'h8000});
        check("cfg_no_ldac", 32'(ldac_pulses), 32'd0);

        // Single write: latency, word format, LDAC width
        clear_log();
        wr(3'd3, 10'h155);
        check("lat_arb_tvalid", 32'(m_if.m_tvalid), 32'd0);
        @(negedge clkin);
        check("lat_send_tvalid", 32'(m_if.m_tvalid), 32'd1);
        check("lat_send_tdata", 32'(m_if.m_tdata), 32'h0155);
        check("lat_send_tuser", 32'(m_if.m_tuser), 32'd3);
        wait_idle("ch3");
        check("ch3_count", 32'(words.size()), 32'd1);
        check("ch3_ldac_pulses", 32'(ldac_pulses), 32'd1);
        check("ch3_ldac_width", 32'(last_w), 32'd4);

        // Burst 0,5,7 from rr=7 after a fresh reset
        do_reset(1'b0);
        clear_log();
        wr(3'd0, 10'h00A);
        wr(3'd5, 10'h05B);
        wr(3'd7, 10'h07C);
        wait_idle("burst");
        check("burst_count", 32'(words.size()), 32'd3);
        check("burst_w0", 32'(words[0]), {13'd0, 3'd0, 16'h000A});
        check("burst_w1", 32'(words[1]), {13'd0, 3'd5, 16'h005B});
        check("burst_w2", 32'(words[2]), {13'd0, 3'd7, 16'h007C});
        check("burst_ldac", 32'(ldac_pulses), 32'd1);

        // Coalescing: two writes to ch2 while ch6 is in flight
        clear_log();
        wr(3'd6, 10'h0AA);
        wr(3'd2, 10'h001);
        wr(3'd2, 10'h3FF);
        check("coal_pending", 32'(pending), 32'h04);
        wait_idle("coal");
        check("coal_count", 32'(words.size()), 32'd2);
        check("coal_w0", 32'(words[0]), {13'd0, 3'd6, 16'h00AA});
        check("coal_w1", 32'(words[1]), {13'd0, 3'd2, 16'h03FF});
        check("coal_ldac", 32'(ldac_pulses), 32'd1);

        // Write to ch4 in the cycle ch4 is granted: resent with new value
        clear_log();
        wr(3'd4, 10'h111);
        wr(3'd4, 10'h222);
        wait_idle("race");
        check("race_count", 32'(words.size()), 32'd2);
        check("race_w0", 32'(words[0]), {13'd0, 3'd4, 16'h0111});
        check("race_w1", 32'(words[1]), {13'd0, 3'd4, 16'h0222});
        check("race_ldac", 32'(ldac_pulses), 32'd1);

        // All eight channels in one batch
        clear_log();
        for (int i = 0; i < 8; i++) wr(3'(i), 10'h100 | 10'(i));
        wait_idle("all8");
        check("all8_count", 32'(words.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("all8_w%0d", i), 32'(words[i]),
                  {13'd0, 3'(i), 16'h0100 | 16'(i)});
        end
        check("all8_ldac", 32'(ldac_pulses), 32'd1);
        check("all8_pending", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
